// File: rtl/brdg_actag_mapper.sv
// PASID-to-acTag mapper: holds one command in stage 1, looks its PASID up
// in a tag table and, on a miss, injects an assign_acTag ahead of it.

// One table entry: a resettable valid bit plus the PASID tag it holds.
module brdg_actag_entry #(
  parameter int PASID_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PASID_W-1:0] wr_tag,
  input  logic               inv_valid,
  input  logic [PASID_W-1:0] inv_pasid,
  input  logic [PASID_W-1:0] lk_pasid,
  output logic               vld,
  output logic               match
);
  logic [PASID_W-1:0] tag;

  // Allocation sets the entry; invalidate clears it when the tag matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      tag <= '0;
    end else if (wr_en) begin
      vld <= 1'b1;
      tag <= wr_tag;
    end else if (inv_valid && tag == inv_pasid) begin
      vld <= 1'b0;
    end
  end

  assign match = vld & (tag == lk_pasid);
endmodule

module brdg_actag_mapper #(
  parameter int IDX_W   = 6,
  parameter int PASID_W = 20,
  parameter int MODE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cfg_actag_base,
  input  logic        tlx_i_cmd_valid,
  input  logic [7:0]  tlx_i_cmd_opcode,
  input  logic [15:0] tlx_i_cmd_afutag,
  input  logic [67:0] tlx_i_cmd_ea_or_obj,
  input  logic [1:0]  tlx_i_cmd_dl,
  input  logic [2:0]  tlx_i_cmd_pl,
  input  logic [19:0] tlx_i_cmd_pasid,
  output logic        tlx_cmd_s1_ready,
  output logic        tlx_o_cmd_valid,
  output logic [7:0]  tlx_o_cmd_opcode,
  output logic [15:0] tlx_o_cmd_afutag,
  output logic [67:0] tlx_o_cmd_ea_or_obj,
  output logic [1:0]  tlx_o_cmd_dl,
  output logic [2:0]  tlx_o_cmd_pl,
  output logic [11:0] tlx_o_cmd_actag,
  output logic [19:0] tlx_o_cmd_pasid,
  input  logic        tlx_afu_cmd_ready,
  output logic        tlx_wdata_rdrq,
  input  logic        inv_valid,
  input  logic [19:0] inv_pasid,
  output logic [31:0] assign_cnt
);
  localparam int N = 1 << IDX_W;
  localparam logic [7:0] ASSIGN_OP = 8'h50;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] afutag;
    logic [67:0] ea_or_obj;
    logic [1:0]  dl;
    logic [2:0]  pl;
    logic [19:0] pasid;
  } cmd_t;

  cmd_t               s1_cmd;
  logic               s1_valid, s1_assigned;
  logic [IDX_W-1:0]   s1_idx, rr_ptr;
  logic [N-1:0]       tbl_vld, tbl_match, tbl_wr;
  logic [PASID_W-1:0] lk_pasid;
  logic [IDX_W-1:0]   dir_idx, hit_idx, victim, out_idx;
  logic               hit, vic_free, issue, use_cmd, s1_adv, do_assign;

  assign lk_pasid = s1_cmd.pasid[PASID_W-1:0];
  assign dir_idx  = s1_cmd.pasid[IDX_W-1:0];

  for (genvar g = 0; g < N; g++) begin : g_ent
    brdg_actag_entry #(.PASID_W(PASID_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (tbl_wr[g]),
      .wr_tag    (lk_pasid),
      .inv_valid (inv_valid),
      .inv_pasid (inv_pasid[PASID_W-1:0]),
      .lk_pasid  (lk_pasid),
      .vld       (tbl_vld[g]),
      .match     (tbl_match[g])
    );
  end

  // Lookup and victim choice; descending loop leaves the lowest index winning.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    victim   = rr_ptr;
    vic_free = 1'b0;
    if (MODE == 0) begin
      hit      = tbl_match[dir_idx];
      hit_idx  = dir_idx;
      victim   = dir_idx;
      vic_free = 1'b1;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (tbl_match[i]) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
        if (!tbl_vld[i]) begin
          vic_free = 1'b1;
          victim   = IDX_W'(i);
        end
      end
    end
  end

  // Invalidate and reset both block issue; a held assign reuses its index.
  assign issue     = s1_valid & tlx_afu_cmd_ready & ~inv_valid & ~rst;
  assign use_cmd   = hit | s1_assigned;
  assign out_idx   = s1_assigned ? s1_idx : hit_idx;
  assign s1_adv    = issue & use_cmd;
  assign do_assign = issue & ~use_cmd;
  assign tbl_wr    = {{(N-1){1'b0}}, do_assign} << victim;

  assign tlx_cmd_s1_ready = ~s1_valid | s1_adv;
  assign tlx_wdata_rdrq   = s1_adv & (s1_cmd.opcode == 8'h20 | s1_cmd.opcode == 8'h30);

  // Stage 1: load on accept, clear on advance, mark assigned after a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_assigned <= 1'b0;
      s1_idx      <= '0;
      s1_cmd      <= '0;
    end else if (tlx_cmd_s1_ready && tlx_i_cmd_valid) begin
      s1_valid    <= 1'b1;
      s1_assigned <= 1'b0;
      s1_cmd      <= {tlx_i_cmd_opcode, tlx_i_cmd_afutag, tlx_i_cmd_ea_or_obj,
                      tlx_i_cmd_dl, tlx_i_cmd_pl, tlx_i_cmd_pasid};
    end else if (s1_adv) begin
      s1_valid    <= 1'b0;
      s1_assigned <= 1'b0;
    end else if (do_assign) begin
      s1_assigned <= 1'b1;
      s1_idx      <= victim;
    end
  end

  // Registered command output; fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      tlx_o_cmd_valid     <= 1'b0;
      tlx_o_cmd_opcode    <= '0;
      tlx_o_cmd_afutag    <= '0;
      tlx_o_cmd_ea_or_obj <= '0;
      tlx_o_cmd_dl        <= '0;
      tlx_o_cmd_pl        <= '0;
      tlx_o_cmd_actag     <= '0;
      tlx_o_cmd_pasid     <= '0;
    end else begin
      tlx_o_cmd_valid <= issue;
      if (s1_adv) begin
        tlx_o_cmd_opcode    <= s1_cmd.opcode;
        tlx_o_cmd_afutag    <= s1_cmd.afutag;
        tlx_o_cmd_ea_or_obj <= s1_cmd.ea_or_obj;
        tlx_o_cmd_dl        <= s1_cmd.dl;
        tlx_o_cmd_pl        <= s1_cmd.pl;
        tlx_o_cmd_actag     <= cfg_actag_base + 12'(out_idx);
        tlx_o_cmd_pasid     <= s1_cmd.pasid;
      end else if (do_assign) begin
        tlx_o_cmd_opcode    <= ASSIGN_OP;
        tlx_o_cmd_afutag    <= s1_cmd.afutag;
        tlx_o_cmd_ea_or_obj <= '0;
        tlx_o_cmd_dl        <= '0;
        tlx_o_cmd_pl        <= '0;
        tlx_o_cmd_actag     <= cfg_actag_base + 12'(victim);
        tlx_o_cmd_pasid     <= s1_cmd.pasid;
      end
    end
  end

  // Round-robin pointer moves only on a full-table eviction; assign counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      assign_cnt <= '0;
    end else if (do_assign) begin
      assign_cnt <= assign_cnt + 32'd1;
      if (!vic_free) rr_ptr <= rr_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_brdg_actag_mapper.sv
// Bench: a DIRECT (IDX_W=6) and an ASSOC (IDX_W=2) mapper share stimulus;
// each is checked every cycle against a transaction-level table model.
module tb_brdg_actag_mapper;
  logic        clk = 1'b0;
  logic        rst, iv, afu_rdy, inv_v;
  logic [11:0] base;
  logic [7:0]  iop;
  logic [15:0] itag;
  logic [67:0] iea;
  logic [1:0]  idl;
  logic [2:0]  ipl;
  logic [19:0] ipas, inv_p;

  logic        d_rdy [2], d_ov [2], d_rdrq [2];
  logic [7:0]  d_op  [2];
  logic [15:0] d_tag [2];
  logic [67:0] d_ea  [2];
  logic [1:0]  d_dl  [2];
  logic [2:0]  d_pl  [2];
  logic [11:0] d_act [2];
  logic [19:0] d_pas [2];
  logic [31:0] d_cnt [2];

  always #5 clk = ~clk;

  brdg_actag_mapper #(.IDX_W(6), .PASID_W(20), .MODE(0)) u_dir (
    .clk(clk), .rst(rst), .cfg_actag_base(base),
    .tlx_i_cmd_valid(iv), .tlx_i_cmd_opcode(iop), .tlx_i_cmd_afutag(itag),
    .tlx_i_cmd_ea_or_obj(iea), .tlx_i_cmd_dl(idl), .tlx_i_cmd_pl(ipl),
    .tlx_i_cmd_pasid(ipas), .tlx_cmd_s1_ready(d_rdy[0]),
    .tlx_o_cmd_valid(d_ov[0]), .tlx_o_cmd_opcode(d_op[0]), .tlx_o_cmd_afutag(d_tag[0]),
    .tlx_o_cmd_ea_or_obj(d_ea[0]), .tlx_o_cmd_dl(d_dl[0]), .tlx_o_cmd_pl(d_pl[0]),
    .tlx_o_cmd_actag(d_act[0]), .tlx_o_cmd_pasid(d_pas[0]),
    .tlx_afu_cmd_ready(afu_rdy), .tlx_wdata_rdrq(d_rdrq[0]),
    .inv_valid(inv_v), .inv_pasid(inv_p), .assign_cnt(d_cnt[0]));

  brdg_actag_mapper #(.IDX_W(2), .PASID_W(20), .MODE(1)) u_asc (
    .clk(clk), .rst(rst), .cfg_actag_base(base),
    .tlx_i_cmd_valid(iv), .tlx_i_cmd_opcode(iop), .tlx_i_cmd_afutag(itag),
    .tlx_i_cmd_ea_or_obj(iea), .tlx_i_cmd_dl(idl), .tlx_i_cmd_pl(ipl),
    .tlx_i_cmd_pasid(ipas), .tlx_cmd_s1_ready(d_rdy[1]),
    .tlx_o_cmd_valid(d_ov[1]), .tlx_o_cmd_opcode(d_op[1]), .tlx_o_cmd_afutag(d_tag[1]),
    .tlx_o_cmd_ea_or_obj(d_ea[1]), .tlx_o_cmd_dl(d_dl[1]), .tlx_o_cmd_pl(d_pl[1]),
    .tlx_o_cmd_actag(d_act[1]), .tlx_o_cmd_pasid(d_pas[1]),
    .tlx_afu_cmd_ready(afu_rdy), .tlx_wdata_rdrq(d_rdrq[1]),
    .inv_valid(inv_v), .inv_pasid(inv_p), .assign_cnt(d_cnt[1]));

  typedef struct {
    logic [7:0]  op;
    logic [15:0] tag;
    logic [67:0] ea;
    logic [1:0]  dl;
    logic [2:0]  pl;
    logic [19:0] pas;
  } cmd_s;

  // reference model state, one slot per instance
  bit          m_sv [2], m_sa [2], m_ov [2];
  int          m_sidx [2], m_rr [2];
  int unsigned m_cnt [2];
  cmd_s        m_s1 [2], m_out [2];
  logic [11:0] m_act [2];
  bit          tv [2][256];
  logic [19:0] tt [2][256];

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of the spec's behaviour for instance m: compare, then advance.
  task automatic model_cycle(input int m);
    int   n, hidx, idx, vic;
    bit   issue, use_c, adv, asg;
    cmd_s c;
    string nm;
    n    = (m == 0) ? 64 : 4;
    nm   = (m == 0) ? "dir" : "asc";
    c    = m_s1[m];
    hidx = -1;
    if (m == 0) begin
      if (tv[m][int'(c.pas) % n] && tt[m][int'(c.pas) % n] == c.pas) hidx = int'(c.pas) % n;
    end else begin
      for (int i = 0; i < n; i++)
        if (hidx < 0 && tv[m][i] && tt[m][i] == c.pas) hidx = i;
    end
    issue = m_sv[m] && afu_rdy && !inv_v && !rst;
    use_c = (hidx >= 0) || m_sa[m];
    idx   = m_sa[m] ? m_sidx[m] : hidx;
    adv   = issue && use_c;
    asg   = issue && !use_c;

    if (chk_en) begin
      chk({nm, "_ready"}, 128'(d_rdy[m]), 128'(!m_sv[m] || adv));
      chk({nm, "_rdrq"}, 128'(d_rdrq[m]), 128'(adv && (c.op == 8'h20 || c.op == 8'h30)));
      chk({nm, "_ovalid"}, 128'(d_ov[m]), 128'(m_ov[m]));
      chk({nm, "_cnt"}, 128'(d_cnt[m]), 128'(m_cnt[m]));
      if (m_ov[m]) begin
        chk({nm, "_opcode"}, 128'(d_op[m]), 128'(m_out[m].op));
        chk({nm, "_afutag"}, 128'(d_tag[m]), 128'(m_out[m].tag));
        chk({nm, "_actag"}, 128'(d_act[m]), 128'(m_act[m]));
        chk({nm, "_pasid"}, 128'(d_pas[m]), 128'(m_out[m].pas));
        if (m_out[m].op != 8'h50) begin
          chk({nm, "_ea"}, 128'(d_ea[m]), 128'(m_out[m].ea));
          chk({nm, "_dlpl"}, 128'({d_dl[m], d_pl[m]}), 128'({m_out[m].dl, m_out[m].pl}));
        end
      end
    end

    if (rst) begin
      m_sv[m] = 0; m_sa[m] = 0; m_ov[m] = 0; m_rr[m] = 0; m_cnt[m] = 0;
      for (int i = 0; i < 256; i++) tv[m][i] = 0;
      return;
    end
    m_ov[m] = issue;
    if (asg) begin
      vic = -1;
      if (m == 0) vic = int'(c.pas) % n;
      else for (int i = 0; i < n; i++) if (vic < 0 && !tv[m][i]) vic = i;
      if (vic < 0) begin
        vic = m_rr[m];
        m_rr[m] = (m_rr[m] + 1) % n;
      end
      tv[m][vic] = 1; tt[m][vic] = c.pas;
      m_cnt[m]++;
      m_out[m].op = 8'h50; m_out[m].tag = c.tag; m_out[m].pas = c.pas;
      m_act[m] = base + 12'(vic);
      m_sa[m] = 1; m_sidx[m] = vic;
    end
    if (adv) begin
      m_out[m] = c;
      m_act[m] = base + 12'(idx);
    end
    if (inv_v)
      for (int i = 0; i < n; i++) if (tt[m][i] == inv_p) tv[m][i] = 0;
    if ((!m_sv[m] || adv) && iv) begin
      m_sv[m] = 1; m_sa[m] = 0;
      m_s1[m] = '{iop, itag, iea, idl, ipl, ipas};
    end else if (adv) begin
      m_sv[m] = 0; m_sa[m] = 0;
    end
  endtask

  task automatic step();
    #1;
    model_cycle(0);
    model_cycle(1);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic send(input logic [7:0] op, input logic [19:0] pas);
    iv = 1'b1; iop = op; ipas = pas;
    itag = 16'($urandom);
    iea  = {4'($urandom), $urandom, $urandom};
    idl  = 2'($urandom); ipl = 3'($urandom);
    step();
    iv = 1'b0;
  endtask

  function automatic logic [19:0] rnd_pasid();
    return 20'(($urandom_range(0, 1) << 19) | ($urandom_range(0, 2) << 6) | $urandom_range(0, 5));
  endfunction

  initial begin
    rst = 1; iv = 0; afu_rdy = 1; inv_v = 0; inv_p = '0; base = 12'h100;
    iop = '0; itag = '0; iea = '0; idl = '0; ipl = '0; ipas = '0;
    @(negedge clk);
    step();
    chk_en = 1'b1;
    step();
    rst = 0;
    // reset state
    for (int m = 0; m < 2; m++) begin
      chk("rst_ovalid", 128'(d_ov[m]), 128'(0));
      chk("rst_fields", 128'({d_op[m], d_act[m], d_pas[m], d_tag[m]}), 128'(0));
      chk("rst_cnt", 128'(d_cnt[m]), 128'(0));
      chk("rst_ready", 128'(d_rdy[m]), 128'(1));
    end

    // miss then repeat-hit
    send(8'h10, 20'h00041); idle(4);
    send(8'h10, 20'h00041); idle(4);
    chk("planA_dir_cnt", 128'(d_cnt[0]), 128'(1));
    chk("planA_asc_cnt", 128'(d_cnt[1]), 128'(1));
    // index conflict in DIRECT
    send(8'h10, 20'h00081); idle(4);
    send(8'h10, 20'h00041); idle(4);
    chk("planB_dir_cnt", 128'(d_cnt[0]), 128'(3));
    chk("planB_asc_cnt", 128'(d_cnt[1]), 128'(2));

    // ASSOC fill and round-robin eviction
    rst = 1; step(); rst = 0;
    for (int p = 1; p <= 6; p++) begin
      send(8'h10, 20'(p)); idle(4);
    end
    send(8'h10, 20'h3); idle(1);
    chk("planC_dir_hit", 128'({d_ov[0], d_act[0]}), 128'({1'b1, 12'h103}));
    chk("planC_asc_hit", 128'({d_ov[1], d_act[1]}), 128'({1'b1, 12'h102}));
    idle(3);
    chk("planC_dir_cnt", 128'(d_cnt[0]), 128'(6));
    chk("planC_asc_cnt", 128'(d_cnt[1]), 128'(6));

    // invalidate while a hit waits, then invalidate after an assign
    send(8'h10, 20'h3);
    inv_v = 1; inv_p = 20'h3; step(); inv_v = 0;
    idle(4);
    send(8'h10, 20'h7); step();
    inv_v = 1; inv_p = 20'h7; step(); inv_v = 0;
    idle(4);

    // DMA write miss with ready toggling
    send(8'h20, 20'h99);
    afu_rdy = 0; step(); afu_rdy = 1; step(); afu_rdy = 0; step(); afu_rdy = 1;
    idle(4);

    // reset while a command is held after its assign
    send(8'h10, 20'h41); step();
    rst = 1; step(); rst = 0;
    idle(3);
    send(8'h10, 20'h41); idle(4);
    chk("rst_mid_dir_cnt", 128'(d_cnt[0]), 128'(1));

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      iv      = ($urandom_range(0, 9) < 6);
      iop     = ($urandom_range(0, 3) == 0) ? 8'h20 : ($urandom_range(0, 2) == 0) ? 8'h30 : 8'h10;
      ipas    = rnd_pasid();
      itag    = 16'($urandom);
      iea     = {4'($urandom), $urandom, $urandom};
      idl     = 2'($urandom); ipl = 3'($urandom);
      afu_rdy = ($urandom_range(0, 3) != 0);
      inv_v   = ($urandom_range(0, 19) == 0);
      inv_p   = rnd_pasid();
      rst     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) base = 12'($urandom);
      step();
    end
    iv = 0; inv_v = 0; rst = 0; afu_rdy = 1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/brdg_actag_mapper.md
# brdg_actag_mapper

Parametrised PASID-to-acTag mapper that sits between the bridge command arbiter and the AFU→TLX command port. It tracks which acTag currently holds which PASID in a table of 2^IDX_W entries storing full PASIDs. On a miss it injects an assign_acTag command ahead of the user command. It supports direct-indexed and fully-associative allocation, PASID invalidation, and an assign counter for debug registers.

## Interface
Parameters:
- IDX_W, 6, log2 of table depth (acTags in use = 2^IDX_W, range 1..8)
- PASID_W, 20, stored/compared PASID width (≤20); upper input bits are ignored
- MODE, 0, 0 = DIRECT (index = pasid[IDX_W-1:0]); 1 = ASSOC (CAM lookup, allocate on miss)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_actag_base  in  12  acTag offset added to table index
- tlx_i_cmd_valid  in  1  input command valid; transfers when tlx_cmd_s1_ready=1
- tlx_i_cmd_opcode / afutag / ea_or_obj / dl / pl / pasid  in  8/16/68/2/3/20  input command fields
- tlx_cmd_s1_ready  out  1  stage-1 can accept a command this cycle
- tlx_o_cmd_valid  out  1  one-cycle pulse per issued command
- tlx_o_cmd_opcode / afutag / ea_or_obj / dl / pl / actag / pasid  out  8/16/68/2/3/12/20  issued command fields
- tlx_afu_cmd_ready  in  1  downstream may take a command this cycle
- tlx_wdata_rdrq  out  1  pulse: fetch write data for the DMA write advancing this cycle
- inv_valid  in  1  invalidate request (single-cycle pulse)
- inv_pasid  in  20  PASID to invalidate
- assign_cnt  out  32  number of assign_acTag commands issued (wraps)

## Operation
- Stage 1 is one register holding the command plus s1_valid, s1_assigned and s1_idx. tlx_cmd_s1_ready = !s1_valid | s1_adv, where s1_adv means the user command leaves stage 1 this cycle.
- The lookup is combinational on stage 1. The table has per-entry valid bits in flops (reset-clearable) and PASID tags.
  - DIRECT: hit = valid[pasid[IDX_W-1:0]] & tag == pasid[PASID_W-1:0].
  - ASSOC: hit = any valid entry whose tag matches; idx = the lowest matching index.
- Issue cycle requires s1_valid & tlx_afu_cmd_ready & !inv_valid. Invalidate has priority and stalls stage 1 for that cycle.
  - If hit, or s1_assigned=1: issue the user command with actag = cfg_actag_base + idx (12-bit, mod 4096), using the held s1_idx when s1_assigned=1. s1_adv=1.
  - Otherwise (miss): choose a victim, write tag=pasid and valid=1, issue opcode 0x50 (assign_acTag) carrying actag=base+victim and the command's pasid and afutag. Set s1_assigned=1 and s1_idx=victim. The stage does not advance; the user command follows on the next issue cycle.
- Victim in DIRECT mode is the indexed entry, overwriting any previous entry.
- Victim in ASSOC mode is the lowest-index invalid entry. If none is invalid, the victim is rr_ptr, and rr_ptr increments (wrapping at 2^IDX_W) only on that eviction.
- Invalidate clears valid on every entry whose tag == inv_pasid[PASID_W-1:0]. A held s1_assigned command still issues with its s1_idx.
- tlx_wdata_rdrq = s1_adv & (opcode == 0x20 | opcode == 0x30). It is never asserted for an assign_acTag.
- assign_cnt increments by 1 per issued assign_acTag.

## Timing
- Reset (synchronous): tlx_o_cmd_valid=0, all output fields=0, tlx_wdata_rdrq=0, assign_cnt=0, s1_valid=0, s1_assigned=0, all table valid bits=0, rr_ptr=0. tlx_cmd_s1_ready=1 in the first cycle after reset.
- Outputs are registered. tlx_o_cmd_valid pulses in the cycle after the issue cycle.
- Latency: a hit issues 2 cycles after input acceptance (accept at N, output valid at N+2). A miss puts the assign at N+2 and the user command at N+3 or later.
- Throughput: one hit per cycle with ready held high. A miss costs one extra cycle.
- The following command may be accepted in the same cycle the current one advances.
- When tlx_afu_cmd_ready=0: nothing issues, stage 1 holds, tlx_wdata_rdrq=0, and the table is unchanged.
- Reset asserted mid-operation drops any held command and any pending assign without issuing either.

## Test plan
- DIRECT, base=0x100: pasid 0x00041 → assign (0x50, actag 0x101) then cmd (actag 0x101); a repeat of pasid 0x00041 → cmd only at N+2; assign_cnt=1.
- DIRECT conflict: pasid 0x00041 then 0x00081 (same index 1) → second re-assigns actag 0x101; pasid 0x00041 again → third assign; assign_cnt=3.
- ASSOC, IDX_W=2: pasids 1,2,3,4 fill entries 0..3; pasid 5 evicts entry 0 (rr_ptr→1); pasid 6 evicts entry 1; pasid 3 hits idx 2.
- DMA write opcode 0x20 on a miss: tlx_wdata_rdrq pulses only in the user-command issue cycle, never in the assign cycle; ready toggling 1-0-1 delays both outputs accordingly.
- inv_valid with pasid 3 while a hit command waits in stage 1: the command stalls one cycle, then misses and re-assigns; inv_valid in the cycle after an assign: the user command still issues with the held actag.
- rst asserted while a command is held after its assign: no output follows, and after release all lookups miss.
